// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder
//
// Stream source for the x and f inputs of a conv_128_32 convolution engine.
// It holds one input vector (LEN_X words) and one filter (LEN_F words),
// which are loaded through a write port while idle. On start, both are
// streamed out on two independent valid/ready channels. Each channel
// honours its own backpressure.
//
// Build option:
//   FEEDER_THROTTLE_EN - a 16-bit LFSR gates when each channel may raise
//                        valid. The resulting irregular valid pattern is
//                        used to stress the engine. When the macro is not
//                        defined there is no LFSR, and valid is raised
//                        whenever a word is pending.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset; clears both memories
//   ld_we         preload write strobe (honoured only while idle)
//   ld_sel        0 = x memory, 1 = f memory
//   ld_addr       word address; writes beyond the selected length are dropped
//   ld_data       preload word
//   start         single-cycle run request (honoured only while idle)
//   busy          high while streaming
//   done          one-cycle pulse once both channels have finished
//   m_data_out_x  x stream data (0 when m_valid_x is low)
//   m_valid_x     x stream valid
//   m_ready_x     x stream ready from the engine
//   m_data_out_f  f stream data (0 when m_valid_f is low)
//   m_valid_f     f stream valid
//   m_ready_f     f stream ready from the engine
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | preload writes accepted, waiting for start
// RUN   | both channels stream independently until each has sent all words
// DONE  | one-cycle done pulse, then back to IDLE

module conv_stream_feeder #(
    parameter int LEN_X = 128,
    parameter int LEN_F = 32,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_we,
    input  logic                     ld_sel,
    input  logic [$clog2(LEN_X)-1:0] ld_addr,
    input  logic [WIDTH-1:0]         ld_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         m_data_out_x,
    output logic                     m_valid_x,
    input  logic                     m_ready_x,
    output logic [WIDTH-1:0]         m_data_out_f,
    output logic                     m_valid_f,
    input  logic                     m_ready_f
);

    localparam int AW_X = $clog2(LEN_X);
    localparam int AW_F = (LEN_F > 1) ? $clog2(LEN_F) : 1;
    localparam int CW_X = $clog2(LEN_X + 1);
    localparam int CW_F = $clog2(LEN_F + 1);

    localparam logic [CW_X-1:0] X_LAST  = CW_X'(LEN_X);
    localparam logic [CW_F-1:0] F_LAST  = CW_F'(LEN_F);
    localparam logic [AW_X:0]   X_LEN_W = (AW_X + 1)'(LEN_X);
    localparam logic [AW_X:0]   F_LEN_W = (AW_X + 1)'(LEN_F);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [CW_X-1:0]   x_cnt, x_cnt_nx;
    logic [CW_F-1:0]   f_cnt, f_cnt_nx;
    logic              valid_x_nx, valid_f_nx;
    logic              gate_x, gate_f;
    logic              x_addr_ok, f_addr_ok;

    logic [WIDTH-1:0]  xmem [LEN_X];
    logic [WIDTH-1:0]  fmem [LEN_F];

    // ------------------------------------------------------------------
    // Preload address qualification
    // ------------------------------------------------------------------
    generate
        if (LEN_X == (1 << AW_X)) begin : g_x_pow2
            assign x_addr_ok = 1'b1;
        end else begin : g_x_npow2
            assign x_addr_ok = ({1'b0, ld_addr} < X_LEN_W);
        end
    endgenerate

    assign f_addr_ok = ({1'b0, ld_addr} < F_LEN_W);

    // ------------------------------------------------------------------
    // Word memories: flop arrays, written only while idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LEN_X; i++) xmem[i] <= '0;
            for (int i = 0; i < LEN_F; i++) fmem[i] <= '0;
        end else if (ld_we && (state == IDLE)) begin
            if (!ld_sel && x_addr_ok)
                xmem[ld_addr] <= ld_data;
            if (ld_sel && f_addr_ok)
                fmem[ld_addr[AW_F-1:0]] <= ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Valid-raise gating
    // ------------------------------------------------------------------
`ifdef FEEDER_THROTTLE_EN
    logic [15:0] lfsr;

    // Fibonacci form, taps 16,14,13,11, shifting toward bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    assign gate_x = lfsr[0];
    assign gate_f = lfsr[1];
`else
    assign gate_x = 1'b1;
    assign gate_f = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM, counters and valid registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x_cnt     <= '0;
            f_cnt     <= '0;
            m_valid_x <= 1'b0;
            m_valid_f <= 1'b0;
        end else begin
            state     <= state_nx;
            x_cnt     <= x_cnt_nx;
            f_cnt     <= f_cnt_nx;
            m_valid_x <= valid_x_nx;
            m_valid_f <= valid_f_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        x_cnt_nx   = x_cnt;
        f_cnt_nx   = f_cnt;
        valid_x_nx = 1'b0;
        valid_f_nx = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = RUN;
                    x_cnt_nx   = '0;
                    f_cnt_nx   = '0;
                    valid_x_nx = gate_x;
                    valid_f_nx = gate_f;
                end
            end

            RUN: begin
                // Valid is only ever high while the count is below the
                // length, so the counters saturate at the length.
                if (m_valid_x && m_ready_x)
                    x_cnt_nx = x_cnt + 1'b1;
                if (m_valid_f && m_ready_f)
                    f_cnt_nx = f_cnt + 1'b1;

                // The decision uses the post-transfer counts, so the exit
                // also happens when both final transfers land on one edge.
                if ((x_cnt_nx == X_LAST) && (f_cnt_nx == F_LAST)) begin
                    state_nx = DONE;
                end else begin
                    // A stalled word keeps valid regardless of the gate.
                    valid_x_nx = (x_cnt_nx < X_LAST) &&
                                 ((m_valid_x && !m_ready_x) || gate_x);
                    valid_f_nx = (f_cnt_nx < F_LAST) &&
                                 ((m_valid_f && !m_ready_f) || gate_f);
                end
            end

            DONE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // The counters and memories hold still while a word is stalled, so the
    // data stays stable until the handshake.
    assign m_data_out_x = m_valid_x ? xmem[x_cnt[AW_X-1:0]] : '0;
    assign m_data_out_f = m_valid_f ? fmem[f_cnt[AW_F-1:0]] : '0;

endmodule

// File: tb/tb_conv_stream_feeder.sv
module tb_conv_stream_feeder;

    localparam int LEN_X = 128;
    localparam int LEN_F = 32;
    localparam int WIDTH = 8;
    localparam int RUN_LIMIT = 5000;

    logic             clk;
    logic             reset;
    logic             ld_we;
    logic             ld_sel;
    logic [6:0]       ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] m_data_out_x;
    logic             m_valid_x;
    logic             m_ready_x;
    logic [WIDTH-1:0] m_data_out_f;
    logic             m_valid_f;
    logic             m_ready_f;

    conv_stream_feeder #(.LEN_X(LEN_X), .LEN_F(LEN_F), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_we        (ld_we),
        .ld_sel       (ld_sel),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .m_data_out_x (m_data_out_x),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x),
        .m_data_out_f (m_data_out_f),
        .m_valid_f    (m_valid_f),
        .m_ready_f    (m_ready_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int px;       // percent of cycles with m_ready_x high
        int pf;       // percent of cycles with m_ready_f high
        bit glitch;   // extra start pulse at x word 20
        bit ldrun;    // preload write to x[3] during the run
        bit stall;    // hold m_ready_x low 10 cycles at x word 5
    } run_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [WIDTH-1:0] xm [LEN_X];
    logic [WIDTH-1:0] fm [LEN_F];
    logic [WIDTH-1:0] qx [$];
    logic [WIDTH-1:0] qf [$];

    int xt, ft, done_cnt, first_x, last_x, last_f, start_cyc, stall_seen;
    bit stall_run = 1'b0;
    logic pvx, prx, pvf, prf;
    logic [WIDTH-1:0] pdx, pdf;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and scoreboard: samples on the falling edge, where valid,
    // ready and data are stable ahead of the next rising edge.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        cyc++;
        if (!reset) begin
            pvx = 1'b0; prx = 1'b0; pvf = 1'b0; prf = 1'b0;
        end else begin
            if (start && !busy && !done) begin
                xt = 0; ft = 0; done_cnt = 0;
                first_x = -1; last_x = -1; last_f = -1;
                start_cyc = cyc; stall_seen = 0;
            end

            if (pvx && !prx) begin
                chk("x_valid_held", m_valid_x, 1);
                chk("x_data_held", $signed(m_data_out_x), $signed(pdx));
            end
            if (pvf && !prf) begin
                chk("f_valid_held", m_valid_f, 1);
                chk("f_data_held", $signed(m_data_out_f), $signed(pdf));
            end

            if (stall_run && m_valid_x && !m_ready_x && xt == 5) begin
                stall_seen++;
                chk("x_stall_word", $signed(m_data_out_x), $signed(xm[5]));
            end

            if (m_valid_x && m_ready_x) begin
                if (qx.size() == 0) chk("x_xfer_beyond_len", xt, LEN_X - 1);
                else begin
                    e = qx.pop_front();
                    chk("x_data", $signed(m_data_out_x), $signed(e));
                end
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                xt++;
            end
            if (m_valid_f && m_ready_f) begin
                if (qf.size() == 0) chk("f_xfer_beyond_len", ft, LEN_F - 1);
                else begin
                    e = qf.pop_front();
                    chk("f_data", $signed(m_data_out_f), $signed(e));
                end
                last_f = cyc;
                ft++;
            end

            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", busy, 0);
                chk("done_latency", cyc, ((last_x > last_f) ? last_x : last_f) + 1);
            end

            pvx = m_valid_x; prx = m_ready_x; pdx = m_data_out_x;
            pvf = m_valid_f; prf = m_ready_f; pdf = m_data_out_f;
        end
    end

    task automatic push_expected();
        qx.delete();
        qf.delete();
        for (int i = 0; i < LEN_X; i++) qx.push_back(xm[i]);
        for (int i = 0; i < LEN_F; i++) qf.push_back(fm[i]);
    endtask

    task automatic issue_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic preload();
        ld_we = 1'b1;
        for (int i = 0; i < LEN_X; i++) begin
            ld_sel = 1'b0; ld_addr = 7'(i); ld_data = 8'(i - 128);
            xm[i] = 8'(i - 128);
            @(posedge clk); #1;
        end
        for (int i = 0; i < LEN_F; i++) begin
            ld_sel = 1'b1; ld_addr = 7'(i); ld_data = 8'(i - 64);
            fm[i] = 8'(i - 64);
            @(posedge clk); #1;
        end
        // Beyond LEN_F: must be dropped, not aliased onto f[8].
        ld_sel = 1'b1; ld_addr = 7'd40; ld_data = 8'h07;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic run_one(input run_t r);
        int n = 0;
        int left = 10;
        bit glitched = 1'b0;
        bit ld_done = 1'b0;
        push_expected();
        stall_run = r.stall;
        issue_start();
        while (done_cnt == 0 && n < RUN_LIMIT) begin
            if (r.stall && xt == 5 && left > 0) begin
                m_ready_x = 1'b0;
                if (m_valid_x) left--;
            end else begin
                m_ready_x = ($urandom_range(99) < r.px);
            end
            m_ready_f = ($urandom_range(99) < r.pf);
            start = r.glitch && xt == 20 && !glitched;
            if (start) glitched = 1'b1;
            ld_we = r.ldrun && xt >= 1 && !ld_done;
            if (ld_we) begin
                ld_done = 1'b1;
                ld_sel = 1'b0; ld_addr = 7'd3; ld_data = 8'h55;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; ld_we = 1'b0;
        chk("done_within_budget", done_cnt, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", done_cnt, 1);
        chk("x_xfer_count", xt, LEN_X);
        chk("f_xfer_count", ft, LEN_F);
        chk("x_queue_empty", qx.size(), 0);
        chk("f_queue_empty", qf.size(), 0);
        chk("busy_idle", busy, 0);
        chk("valid_x_idle", m_valid_x, 0);
        chk("valid_f_idle", m_valid_f, 0);
        if (r.stall) begin
            chk("stall_cycles", stall_seen, 10);
            chk("f_done_before_x", (last_f < last_x), 1);
        end
`ifndef FEEDER_THROTTLE_EN
        if (r.px == 100 && r.pf == 100) begin
            chk("x_first_cycle", first_x, start_cyc + 1);
            chk("x_consecutive", last_x - first_x, LEN_X - 1 + (r.stall ? 10 : 0));
        end
`endif
        stall_run = 1'b0;
    endtask

    initial begin
        run_t tbl [7];
        int n;
        tbl[0] = '{100, 100, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{100, 100, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{100, 100, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{100, 100, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{60,  40,  1'b0, 1'b0, 1'b0};
        tbl[5] = '{30,  80,  1'b1, 1'b1, 1'b0};
        tbl[6] = '{50,  50,  1'b0, 1'b0, 1'b0};

        reset = 1'b0; ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; m_ready_x = 1'b0; m_ready_f = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid_x", m_valid_x, 0);
        chk("rst_valid_f", m_valid_f, 0);
        chk("rst_data_x", m_data_out_x, 0);
        chk("rst_data_f", m_data_out_f, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        preload();
        for (int i = 0; i < 7; i++) run_one(tbl[i]);

        // Asynchronous reset in the middle of a run.
        push_expected();
        issue_start();
        m_ready_x = 1'b1; m_ready_f = 1'b1;
        n = 0;
        while (xt < 50 && n < RUN_LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_x_word_50", xt, 50);
        #3 reset = 1'b0;
        #1;
        chk("abort_valid_x", m_valid_x, 0);
        chk("abort_valid_f", m_valid_f, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data_x", m_data_out_x, 0);
        qx.delete(); qf.delete();
        for (int i = 0; i < LEN_X; i++) xm[i] = '0;
        for (int i = 0; i < LEN_F; i++) fm[i] = '0;
        @(posedge clk); #1 reset = 1'b1;

        // No reload: memories were cleared, so every word streams as 0.
        run_one(tbl[0]);
        run_one(tbl[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
